// File: rtl/clock_select_controller.sv
// Sequencer for the CLOCK_MUX select: quiesce the muxed-clock logic, flip select, settle, release.
// Optional quiesce-ack timeout and sticky error flag are built when CLOCK_SELECT_TIMEOUT_EN is defined.
module clock_select_controller #(
    parameter logic        RESET_SELECT   = 1'b1,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rstnn,
    input  logic req_valid,
    input  logic req_select,
    output logic req_ready,
    output logic quiesce_req,
    input  logic quiesce_ack,
    output logic select,
    output logic busy,
    output logic switch_done,
    output logic switch_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        SETTLE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

    // The shared counter must be able to hold both the settle and timeout reload values.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range for CNT_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range for CNT_WIDTH");
    end

    state_t               state_q, state_d;
    logic                 select_q, select_d;
    logic                 target_q, target_d;
    logic                 quiesce_req_q, quiesce_req_d;
    logic                 busy_q, busy_d;
    logic                 switch_done_q, switch_done_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

`ifdef CLOCK_SELECT_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic switch_error_q, switch_error_d;
`endif

    always_comb begin
        state_d       = state_q;
        select_d      = select_q;
        target_d      = target_q;
        quiesce_req_d = quiesce_req_q;
        switch_done_d = 1'b0;
        cnt_d         = cnt_q;
`ifdef CLOCK_SELECT_TIMEOUT_EN
        switch_error_d = switch_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_select == select_q) begin
                        switch_done_d = 1'b1;
                    end else begin
                        target_d      = req_select;
                        state_d       = QUIESCE;
                        quiesce_req_d = 1'b1;
                        cnt_d         = '0;
`ifdef CLOCK_SELECT_TIMEOUT_EN
                        switch_error_d = 1'b0;
`endif
                    end
                end
            end
            QUIESCE: begin
                // select only moves here, while the downstream logic reports idle.
                if (quiesce_ack) begin
                    select_d = target_q;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
`ifdef CLOCK_SELECT_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    switch_error_d = 1'b1;
                    quiesce_req_d  = 1'b0;
                    state_d        = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    quiesce_req_d = 1'b0;
                    state_d       = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                if (!quiesce_ack) begin
                    switch_done_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q       <= IDLE;
            select_q      <= RESET_SELECT;
            target_q      <= RESET_SELECT;
            quiesce_req_q <= 1'b0;
            busy_q        <= 1'b0;
            switch_done_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            select_q      <= select_d;
            target_q      <= target_d;
            quiesce_req_q <= quiesce_req_d;
            busy_q        <= busy_d;
            switch_done_q <= switch_done_d;
            cnt_q         <= cnt_d;
        end
    end

`ifdef CLOCK_SELECT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            switch_error_q <= 1'b0;
        end else begin
            switch_error_q <= switch_error_d;
        end
    end
    assign switch_error = switch_error_q;
`else
    assign switch_error = 1'b0;
`endif

    assign req_ready   = (state_q == IDLE);
    assign quiesce_req = quiesce_req_q;
    assign select      = select_q;
    assign busy        = busy_q;
    assign switch_done = switch_done_q;

endmodule

// File: tb/tb_clock_select_controller.sv
// Directed bench for clock_select_controller (SETTLE_CYCLES=16, TIMEOUT_CYCLES=255).
// The timeout scenario runs only when CLOCK_SELECT_TIMEOUT_EN is defined.
module tb_clock_select_controller;

    logic clk = 1'b0;
    logic rstnn;
    logic req_valid;
    logic req_select;
    logic req_ready;
    logic quiesce_req;
    logic quiesce_ack;
    logic select;
    logic busy;
    logic switch_done;
    logic switch_error;

    int checks = 0;
    int errors = 0;

    clock_select_controller #(
        .RESET_SELECT  (1'b1),
        .SETTLE_CYCLES (16),
        .CNT_WIDTH     (8),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk         (clk),
        .rstnn       (rstnn),
        .req_valid   (req_valid),
        .req_select  (req_select),
        .req_ready   (req_ready),
        .quiesce_req (quiesce_req),
        .quiesce_ack (quiesce_ack),
        .select      (select),
        .busy        (busy),
        .switch_done (switch_done),
        .switch_error(switch_error)
    );

    always #5 clk = ~clk;

    // Each call lands 1ns after a rising edge: outputs are settled, new inputs are set up.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rstnn       = 1'b0;
        req_valid   = 1'b0;
        req_select  = 1'b0;
        quiesce_ack = 1'b0;

        // Test 1: reset values
        tick(2);
        chk("rst_select", select, 1'b1);
        chk("rst_quiesce_req", quiesce_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_switch_done", switch_done, 1'b0);
        chk("rst_switch_error", switch_error, 1'b0);
        rstnn = 1'b1;
        tick(2);

        // Test 3: same-select request completes without quiescing
        req_valid  = 1'b1;
        req_select = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk("same_done", switch_done, 1'b1);
        chk("same_no_quiesce", quiesce_req, 1'b0);
        chk("same_busy", busy, 1'b0);
        chk("same_select", select, 1'b1);
        tick(1);
        chk("same_done_clear", switch_done, 1'b0);

        // Test 4: delayed ack, second request held while busy
        req_valid  = 1'b1;
        req_select = 1'b0;
        chk("t4_ready_idle", req_ready, 1'b1);
        tick(1);                               // T+1
        req_select = 1'b1;
        chk("t4_quiesce_req", quiesce_req, 1'b1);
        chk("t4_busy", busy, 1'b1);
        chk("t4_ready_busy", req_ready, 1'b0);
        chk("t4_select_hold", select, 1'b1);
        tick(9);                               // T+10
        chk("t4_select_wait_ack", select, 1'b1);
        chk("t4_quiesce_wait", quiesce_req, 1'b1);
        quiesce_ack = 1'b1;
        tick(1);                               // T+11
        chk("t4_select_after_ack", select, 1'b0);
        chk("t4_ready_settle", req_ready, 1'b0);
        tick(16);                              // T+27
        chk("t4_release_qreq", quiesce_req, 1'b0);
        chk("t4_release_done", switch_done, 1'b0);
        tick(1);                               // T+28
        quiesce_ack = 1'b0;
        chk("t4_release_wait", switch_done, 1'b0);
        tick(1);                               // T+29
        chk("t4_first_done", switch_done, 1'b1);
        chk("t4_first_ready", req_ready, 1'b1);
        chk("t4_first_select", select, 1'b0);
        tick(1);                               // T+30
        req_valid   = 1'b0;
        quiesce_ack = 1'b1;
        chk("t4_second_accept", quiesce_req, 1'b1);
        chk("t4_second_busy", busy, 1'b1);
        chk("t4_second_done_clear", switch_done, 1'b0);
        tick(1);                               // T+31
        chk("t4_second_select", select, 1'b1);
        tick(16);                              // T+47
        chk("t4_second_release", quiesce_req, 1'b0);
        tick(1);                               // T+48
        quiesce_ack = 1'b0;
        tick(1);                               // T+49
        chk("t4_second_done", switch_done, 1'b1);
        tick(1);                               // T+50
        chk("t4_no_dup_done", switch_done, 1'b0);
        chk("t4_no_dup_quiesce", quiesce_req, 1'b0);
        chk("t4_final_select", select, 1'b1);

        // Test 5: asynchronous reset during SETTLE
        req_valid   = 1'b1;
        req_select  = 1'b0;
        quiesce_ack = 1'b1;
        tick(1);
        req_valid = 1'b0;
        tick(1);
        chk("t5_select_switched", select, 1'b0);
        tick(3);
        chk("t5_in_settle", quiesce_req, 1'b1);
        rstnn = 1'b0;
        #1;
        chk("t5_async_qreq", quiesce_req, 1'b0);
        chk("t5_async_select", select, 1'b1);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_ready", req_ready, 1'b1);
        quiesce_ack = 1'b0;
        tick(2);
        rstnn = 1'b1;
        tick(1);

        // Test 2: full switch to 0 with ack held high
        req_valid   = 1'b1;
        req_select  = 1'b0;
        quiesce_ack = 1'b1;
        chk("t2_ready", req_ready, 1'b1);
        tick(1);                               // T+1
        req_valid = 1'b0;
        chk("t2_qreq_t1", quiesce_req, 1'b1);
        chk("t2_select_t1", select, 1'b1);
        tick(1);                               // T+2
        chk("t2_select_t2", select, 1'b0);
        tick(15);                              // T+17
        chk("t2_qreq_t17", quiesce_req, 1'b1);
        tick(1);                               // T+18
        chk("t2_qreq_t18", quiesce_req, 1'b0);
        chk("t2_done_t18", switch_done, 1'b0);
        tick(1);                               // T+19
        quiesce_ack = 1'b0;
        chk("t2_done_t19", switch_done, 1'b0);
        tick(1);                               // T+20
        chk("t2_done_t20", switch_done, 1'b1);
        chk("t2_busy_t20", busy, 1'b0);
        tick(1);                               // T+21
        chk("t2_done_t21", switch_done, 1'b0);
        chk("t2_select_final", select, 1'b0);

`ifdef CLOCK_SELECT_TIMEOUT_EN
        // Test 6: quiesce-ack timeout
        req_valid  = 1'b1;
        req_select = 1'b1;
        tick(1);                               // T+1
        req_valid = 1'b0;
        chk("t6_qreq_start", quiesce_req, 1'b1);
        tick(254);                             // T+255
        chk("t6_qreq_last", quiesce_req, 1'b1);
        chk("t6_error_pre", switch_error, 1'b0);
        tick(1);                               // T+256
        chk("t6_qreq_drop", quiesce_req, 1'b0);
        chk("t6_error_set", switch_error, 1'b1);
        chk("t6_select_kept", select, 1'b0);
        tick(1);                               // T+257
        chk("t6_done", switch_done, 1'b1);
        chk("t6_error_sticky", switch_error, 1'b1);
        req_valid   = 1'b1;
        req_select  = 1'b1;
        quiesce_ack = 1'b1;
        tick(1);
        req_valid = 1'b0;
        chk("t6_error_cleared", switch_error, 1'b0);
        tick(1);
        chk("t6_retry_select", select, 1'b1);
`else
        chk("no_timeout_error_tied", switch_error, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
